// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store front end for the 4096x32 data memory
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-3:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_dpra,
    input  logic [DATA_W-1:0] mem_dpo
);

`ifdef LSU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;
`endif

    state_t              state, next_state;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic                we_q;
    logic [DATA_W-1:0]   wd_q;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   merged;
    logic                misaligned;

    assign misaligned = (req_size == 2'b01 && req_addr[0]) ||
                        (req_size[1] && req_addr[1:0] != 2'b00);

    assign req_ready = (state == S_IDLE);
    assign mem_dpra  = addr_q[ADDR_W-1:2];
    assign mem_a     = addr_q[ADDR_W-1:2];
    assign mem_d     = wd_q;
    assign mem_we    = (state == S_WR) && !rst;

    // Lane extraction; half lanes use addr[1] only, which also force-aligns odd halves
    always_comb begin
        byte_lane = 8'h00;
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_dpo[7:0];
            2'd1:    byte_lane = mem_dpo[15:8];
            2'd2:    byte_lane = mem_dpo[23:16];
            default: byte_lane = mem_dpo[31:24];
        endcase
        half_lane = addr_q[1] ? mem_dpo[31:16] : mem_dpo[15:0];
        load_data = mem_dpo;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_data = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_data = mem_dpo;
        endcase
    end

    always_comb begin
        merged = mem_dpo;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wd_q[7:0];
                2'd1:    merged[15:8]  = wd_q[7:0];
                2'd2:    merged[23:16] = wd_q[7:0];
                default: merged[31:24] = wd_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (addr_q[1]) merged[31:16] = wd_q[15:0];
            else           merged[15:0]  = wd_q[15:0];
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned)                 next_state = S_ERR;
                    else if (req_we && req_size[1]) next_state = S_WR;
                    else                            next_state = S_RD;
`else
                    if (req_we && req_size[1]) next_state = S_WR;
                    else                       next_state = S_RD;
`endif
                end
            end
            S_RD:    next_state = we_q ? S_WR : S_IDLE;
            S_WR:    next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= next_state;
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        we_q   <= req_we;
                        wd_q   <= req_wdata;
                    end
                end
                S_RD: begin
                    if (we_q) begin
                        wd_q <= merged;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                S_WR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) resp_err <= 1'b0;
        else     resp_err <= (state == S_ERR);
    end
`else
    assign resp_err = 1'b0;
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

endmodule
